// File: rtl/ahbl_sram16_ctrl.sv
// rtl/ahbl_sram16_ctrl.sv - AHB-Lite slave bridging the 32-bit bus onto a 16-bit asynchronous SRAM
module ahbl_sram16_ctrl #(
   parameter int W_HADDR  = 32,
   parameter int W_SADDR  = 18,
   parameter int T_ACCESS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ahbls_hready,
   output logic               ahbls_hready_resp,
   output logic               ahbls_hresp,
   input  logic [W_HADDR-1:0] ahbls_haddr,
   input  logic               ahbls_hwrite,
   input  logic [1:0]         ahbls_htrans,
   input  logic [2:0]         ahbls_hsize,
   input  logic [2:0]         ahbls_hburst,
   input  logic [3:0]         ahbls_hprot,
   input  logic               ahbls_hmastlock,
   input  logic [31:0]        ahbls_hwdata,
   output logic [31:0]        ahbls_hrdata,
   output logic [W_SADDR-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   localparam logic [3:0] CNT_LOAD = 4'(T_ACCESS - 1);

   typedef enum logic [2:0] {
      IDLE, RD_LO, RD_HI, TURN, WR_LO, WR_LO_REC, WR_HI, WR_HI_REC
   } state_t;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic               word_q;
   logic [15:0]        lo_q;
   logic [W_SADDR-1:0] addr_q;
   logic               ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q;

   logic               strobe_done, rd_final, wr_final, final_cyc, start;
   logic               start_word, start_byte, start_ub_n, start_lb_n;
   logic [W_SADDR-1:0] start_addr;

   always_comb begin
      strobe_done       = (cnt_q == 4'd0);
      rd_final          = strobe_done && ((state_q == RD_LO && !word_q) || state_q == RD_HI);
      wr_final          = (state_q == WR_LO_REC && !word_q) || state_q == WR_HI_REC;
      final_cyc         = rd_final || wr_final;
      ahbls_hready_resp = (state_q == IDLE) || final_cyc;
      start             = ahbls_hready && ahbls_htrans[1] && ahbls_hready_resp;

      start_word = ahbls_hsize[2] | ahbls_hsize[1];
      start_byte = (ahbls_hsize == 3'd0);
      start_lb_n = start_byte & ahbls_haddr[0];
      start_ub_n = start_byte & ~ahbls_haddr[0];
      start_addr = ahbls_haddr[W_SADDR:1];
      if (start_word)
         start_addr[0] = 1'b0;

      // High half of a word read comes straight off the pads; low half was latched in RD_LO.
      ahbls_hrdata = 32'h0;
      if (rd_final)
         ahbls_hrdata = {sram_dq_in, (state_q == RD_HI) ? lo_q : sram_dq_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         word_q  <= 1'b0;
         lo_q    <= 16'h0;
         addr_q  <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else if (start) begin
         word_q <= start_word;
         addr_q <= start_addr;
         ub_n_q <= start_ub_n;
         lb_n_q <= start_lb_n;
         cnt_q  <= CNT_LOAD;
         if (!ahbls_hwrite) begin
            state_q <= RD_LO;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
         end else if (rd_final) begin
            // Bus turnaround: let the SRAM release DQ before the pads drive it.
            state_q <= TURN;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
         end else begin
            state_q <= WR_LO;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b0;
            dq_oe_q <= 1'b1;
         end
      end else if (final_cyc) begin
         state_q <= IDLE;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         case (state_q)
            RD_LO: begin
               if (!strobe_done) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  lo_q      <= sram_dq_in;
                  state_q   <= RD_HI;
                  cnt_q     <= CNT_LOAD;
                  addr_q[0] <= 1'b1;
               end
            end
            RD_HI: cnt_q <= cnt_q - 4'd1;
            TURN: begin
               state_q <= WR_LO;
               cnt_q   <= CNT_LOAD;
               ce_n_q  <= 1'b0;
               we_n_q  <= 1'b0;
               dq_oe_q <= 1'b1;
            end
            WR_LO: begin
               if (!strobe_done) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= WR_LO_REC;
                  we_n_q  <= 1'b1;
               end
            end
            WR_LO_REC: begin
               state_q   <= WR_HI;
               cnt_q     <= CNT_LOAD;
               we_n_q    <= 1'b0;
               addr_q[0] <= 1'b1;
            end
            WR_HI: begin
               if (!strobe_done) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= WR_HI_REC;
                  we_n_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ahbls_hresp = 1'b0;
   assign sram_addr   = addr_q;
   assign sram_dq_out = addr_q[0] ? ahbls_hwdata[31:16] : ahbls_hwdata[15:0];
   assign sram_dq_oe  = dq_oe_q;
   assign sram_ce_n   = ce_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;
   assign sram_ub_n   = ub_n_q;
   assign sram_lb_n   = lb_n_q;

   logic unused_inputs;
   assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0],
                            ahbls_haddr[W_HADDR-1:W_SADDR+1]};

endmodule
